fetch_sequencer: RTL and testbench

Instruction-fetch controller that drives the program counter's ld_pc/inc_pc/data_in controls and reads instruction bytes from memory at the PC address. It latches opcode and optional operand bytes into the instruction register, then presents them to the decoder with a valid/ack handshake. It sits between the program counter, instruction memory and the control/decode unit of the RISC-SPM core.

---
 rtl/rv_spm_pkg.sv | 38 +++
 rtl/fetch_timeout_ctr.sv | 38 +++
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_spm_pkg.sv
// Shared definitions for the RISC-SPM fetch path: opcode values, the fetch
// sequencer state encoding and opcode classification helpers.
package rv_spm_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_RD   = 4'b0101;
    localparam logic [3:0] OP_WR   = 4'b0110;
    localparam logic [3:0] OP_BR   = 4'b0111;
    localparam logic [3:0] OP_BRZ  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_HOLD   = 3'd3,
        S_HALT   = 3'd4
    } fetch_state_t;

    // Instructions that carry an operand byte after the opcode byte.
    function automatic logic is_two_byte(input logic [3:0] opcode);
        logic two;
        case (opcode)
            OP_RD, OP_WR, OP_BR, OP_BRZ: two = 1'b1;
            default:                     two = 1'b0;
        endcase
        return two;
    endfunction

    function automatic logic is_halt(input logic [3:0] opcode);
        return (opcode == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory wait watchdog for the fetch sequencer. Down-counter reloaded while
// no wait is in progress; expired flags the TIMEOUT_CYCLES-th consecutive
// wait cycle so the sequencer can abandon the fetch on that edge.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic wait_cyc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count down through a wait run, reload whenever the wait ends.
    always_comb begin
        cnt_d = LOAD;
        if (wait_cyc && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = wait_cyc && (cnt_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller for the RISC-SPM core. Reads opcode and
// optional operand bytes at pc_count, steps the PC, and holds the
// instruction for the decoder until ir_ack. A branch accepted with ir_ack
// loads the PC from branch_target.
// Build option: define FETCH_TIMEOUT_EN to add the memory wait watchdog
// (fetch_fault + halt after TIMEOUT_CYCLES consecutive not-ready cycles).
//
// state    | meaning
// S_IDLE   | leaving reset, start fetching next cycle
// S_FETCH1 | reading opcode byte at pc_count
// S_FETCH2 | reading operand byte at pc_count
// S_HOLD   | instruction presented to decoder (ir_valid)
// S_HALT   | HALT fetched or memory timeout; only clr exits
module fetch_sequencer
    import rv_spm_pkg::*;
#(
    parameter int DATAWIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] pc_count,
    output logic                 ld_pc,
    output logic                 inc_pc,
    output logic [DATAWIDTH-1:0] pc_data,
    output logic                 mem_rd,
    output logic [DATAWIDTH-1:0] mem_addr,
    input  logic                 mem_ready,
    input  logic [DATAWIDTH-1:0] mem_data,
    output logic [DATAWIDTH-1:0] ir_opcode,
    output logic [DATAWIDTH-1:0] ir_operand,
    output logic                 ir_valid,
    input  logic                 ir_ack,
    input  logic                 branch_req,
    input  logic [DATAWIDTH-1:0] branch_target,
    output logic                 halted,
    output logic                 fetch_fault
);

    fetch_state_t         state_q, state_d;
    logic [DATAWIDTH-1:0] ir_opcode_q, ir_opcode_d;
    logic [DATAWIDTH-1:0] ir_operand_q, ir_operand_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 halted_q, halted_d;
    logic                 fetch_fault_q, fetch_fault_d;

    logic [3:0] mem_op;
    logic       wait_cyc;
    logic       timeout_hit;

    assign mem_op   = mem_data[DATAWIDTH-1 -: 4];
    assign mem_addr = pc_count;
    assign wait_cyc = mem_rd && !mem_ready;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .clr      (clr),
        .wait_cyc (wait_cyc),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // Next-state, IR capture and PC/memory control decode.
    always_comb begin
        state_d       = state_q;
        ir_opcode_d   = ir_opcode_q;
        ir_operand_d  = ir_operand_q;
        fetch_fault_d = fetch_fault_q;
        ld_pc         = 1'b0;
        inc_pc        = 1'b0;
        mem_rd        = 1'b0;
        pc_data       = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_opcode_d = mem_data;
                    inc_pc      = 1'b1;
                    if (is_halt(mem_op)) begin
                        state_d = S_HALT;
                    end else if (is_two_byte(mem_op)) begin
                        state_d = S_FETCH2;
                    end else begin
                        ir_operand_d = '0;
                        state_d      = S_HOLD;
                    end
                end else if (timeout_hit) begin
                    fetch_fault_d = 1'b1;
                    state_d       = S_HALT;
                end
            end
            S_FETCH2: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_operand_d = mem_data;
                    inc_pc       = 1'b1;
                    state_d      = S_HOLD;
                end else if (timeout_hit) begin
                    fetch_fault_d = 1'b1;
                    state_d       = S_HALT;
                end
            end
            S_HOLD: begin
                if (ir_ack) begin
                    if (branch_req) begin
                        ld_pc   = 1'b1;
                        pc_data = branch_target;
                    end
                    state_d = S_FETCH1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ir_valid_d = (state_d == S_HOLD);
        halted_d   = (state_d == S_HALT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= S_IDLE;
            ir_opcode_q   <= '0;
            ir_operand_q  <= '0;
            ir_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_opcode_q   <= ir_opcode_d;
            ir_operand_q  <= ir_operand_d;
            ir_valid_q    <= ir_valid_d;
            halted_q      <= halted_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign ir_opcode   = ir_opcode_q;
    assign ir_operand  = ir_operand_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = halted_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural PC and ROM around the sequencer,
// directed programs, and a scoreboard of expected instructions popped by a
// monitor on every decoder handshake.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pc_count;
    logic       ld_pc, inc_pc, mem_rd;
    logic [7:0] pc_data, mem_addr;
    logic       mem_ready = 1'b1;
    logic [7:0] mem_data;
    logic [7:0] ir_opcode, ir_operand;
    logic       ir_valid;
    logic       ir_ack = 1'b0;
    logic       branch_req = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       halted, fetch_fault;

    logic [7:0]  rom [256];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          inc_total = 0;
    int          ld_total = 0;

    fetch_sequencer #(.DATAWIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .clr           (clr),
        .pc_count      (pc_count),
        .ld_pc         (ld_pc),
        .inc_pc        (inc_pc),
        .pc_data       (pc_data),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .ir_opcode     (ir_opcode),
        .ir_operand    (ir_operand),
        .ir_valid      (ir_valid),
        .ir_ack        (ir_ack),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .halted        (halted),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program counter model
    always @(posedge clk or negedge clr) begin
        if (!clr)        pc_count <= 8'h00;
        else if (ld_pc)  pc_count <= pc_data;
        else if (inc_pc) pc_count <= pc_count + 8'h01;
    end

    assign mem_data = rom[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ld_pc"},       ld_pc,       0);
        chk({tag, "_inc_pc"},      inc_pc,      0);
        chk({tag, "_mem_rd"},      mem_rd,      0);
        chk({tag, "_pc_data"},     pc_data,     0);
        chk({tag, "_ir_opcode"},   ir_opcode,   0);
        chk({tag, "_ir_operand"},  ir_operand,  0);
        chk({tag, "_ir_valid"},    ir_valid,    0);
        chk({tag, "_halted"},      halted,      0);
        chk({tag, "_fetch_fault"}, fetch_fault, 0);
    endtask

    // Hold reset two cycles, check reset state, release just after an edge.
    task automatic do_reset();
        clr = 1'b0;
        step(2);
        check_all_zero("reset");
        clr = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each decoder handshake
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (clr) begin
                chk("ld_inc_exclusive", {31'b0, ld_pc & inc_pc}, 0);
                if (inc_pc) inc_total++;
                if (ld_pc)  ld_total++;
                if (ir_valid && ir_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_instr", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_opcode",  ir_opcode,  e[15:8]);
                        chk("sb_operand", ir_operand, e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        int inc_base, ld_base;

        // Linear one-byte fetch, zero-wait memory
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'hF0;
        ir_ack = 1'b1; mem_ready = 1'b1;
        do_reset();
        inc_base = inc_total;
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h2000);
        step(1);
        chk("lin_f1_mem_rd", mem_rd, 1);
        chk("lin_f1_addr", mem_addr, 8'h00);
        chk("lin_f1_inc", inc_pc, 1);
        chk("lin_f1_valid", ir_valid, 0);
        step(1);
        chk("lin_hold_valid", ir_valid, 1);
        chk("lin_hold_opcode", ir_opcode, 8'h10);
        chk("lin_pc1", pc_count, 8'h01);
        step(1);
        chk("lin_f1b_addr", mem_addr, 8'h01);
        step(1);
        chk("lin_ack_to_valid", ir_valid, 1);
        chk("lin_opcode2", ir_opcode, 8'h20);
        chk("lin_pc2", pc_count, 8'h02);
        step(2);
        chk("lin_halted", halted, 1);
        chk("lin_inc_pulses", inc_total - inc_base, 3);
        chk("lin_pc_halt", pc_count, 8'h03);

        // Two-byte fetch
        clear_rom();
        rom[0] = 8'h50; rom[1] = 8'hA5; rom[2] = 8'hF0;
        do_reset();
        exp_q.push_back(16'h50A5);
        step(1);
        chk("two_f1_addr", mem_addr, 8'h00);
        step(1);
        chk("two_f2_valid", ir_valid, 0);
        chk("two_f2_addr", mem_addr, 8'h01);
        chk("two_f2_opcode", ir_opcode, 8'h50);
        chk("two_f2_inc", inc_pc, 1);
        step(1);
        chk("two_valid", ir_valid, 1);
        chk("two_operand", ir_operand, 8'hA5);
        chk("two_pc", pc_count, 8'h02);
        step(3);
        chk("two_halted", halted, 1);

        // Branch: ignored without ack, taken with ack
        clear_rom();
        rom[0] = 8'h10; rom[8'h40] = 8'h30; rom[8'h41] = 8'hF0;
        ir_ack = 1'b0; branch_req = 1'b1; branch_target = 8'h40;
        do_reset();
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h3000);
        ld_base = ld_total;
        step(2);
        for (int i = 0; i < 3; i++) begin
            chk("br_noack_valid", ir_valid, 1);
            chk("br_noack_ld", ld_pc, 0);
            step(1);
        end
        chk("br_noack_ld_count", ld_total - ld_base, 0);
        chk("br_noack_pc", pc_count, 8'h01);
        ir_ack = 1'b1;
        #1;
        chk("br_ld_pc", ld_pc, 1);
        chk("br_pc_data", pc_data, 8'h40);
        chk("br_no_inc", inc_pc, 0);
        step(1);
        branch_req = 1'b0;
        chk("br_pc_target", pc_count, 8'h40);
        chk("br_next_addr", mem_addr, 8'h40);
        chk("br_next_rd", mem_rd, 1);
        chk("br_pc_data_idle", pc_data, 8'h00);
        step(1);
        chk("br_target_opcode", ir_opcode, 8'h30);
        step(3);
        chk("br_halted", halted, 1);
        chk("br_ld_count", ld_total - ld_base, 1);

        // Memory wait states on both bytes
        clear_rom();
        rom[0] = 8'h50; rom[1] = 8'h77; rom[2] = 8'hF0;
        mem_ready = 1'b0;
        do_reset();
        exp_q.push_back(16'h5077);
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("ws_f1_rd", mem_rd, 1);
            chk("ws_f1_addr", mem_addr, 8'h00);
            chk("ws_f1_no_inc", inc_pc, 0);
            chk("ws_f1_ir", ir_opcode, 8'h00);
            step(1);
        end
        mem_ready = 1'b1;
        #1;
        chk("ws_f1_ready_inc", inc_pc, 1);
        step(1);
        mem_ready = 1'b0;
        chk("ws_f2_opcode", ir_opcode, 8'h50);
        chk("ws_f2_pc", pc_count, 8'h01);
        for (int i = 0; i < 2; i++) begin
            chk("ws_f2_rd", mem_rd, 1);
            chk("ws_f2_operand", ir_operand, 8'h00);
            step(1);
        end
        mem_ready = 1'b1;
        step(1);
        chk("ws_valid", ir_valid, 1);
        chk("ws_operand", ir_operand, 8'h77);
        step(3);
        chk("ws_halted", halted, 1);

        // HALT at ROM[3], then stays quiet
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h30; rom[3] = 8'hF0;
        do_reset();
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h3000);
        step(8);
        chk("halt_opcode", ir_opcode, 8'hF0);
        chk("halt_pc", pc_count, 8'h04);
        for (int i = 0; i < 6; i++) begin
            chk("halt_halted", halted, 1);
            chk("halt_no_rd", mem_rd, 0);
            chk("halt_no_valid", ir_valid, 0);
            step(1);
        end

        // Reset asserted mid-FETCH2 then restart
        clear_rom();
        rom[0] = 8'h60; rom[1] = 8'h12; rom[2] = 8'hF0;
        do_reset();
        step(2);
        chk("clr_pre_opcode", ir_opcode, 8'h60);
        chk("clr_pre_rd", mem_rd, 1);
        clr = 1'b0;
        #1;
        check_all_zero("clr_mid");
        step(1);
        clr = 1'b1;
        exp_q.push_back(16'h6012);
        chk("clr_idle_rd", mem_rd, 0);
        chk("clr_idle_pc", pc_count, 8'h00);
        step(1);
        chk("clr_restart_rd", mem_rd, 1);
        chk("clr_restart_addr", mem_addr, 8'h00);
        step(2);
        chk("clr_restart_operand", ir_operand, 8'h12);
        step(3);
        chk("clr_restart_halted", halted, 1);

        // Memory stuck not-ready
        clear_rom();
        rom[0] = 8'h10;
        mem_ready = 1'b0;
        do_reset();
        inc_base = inc_total;
        step(1);
`ifdef FETCH_TIMEOUT_EN
        step(15);
        chk("to_before_fault", fetch_fault, 0);
        chk("to_before_halted", halted, 0);
        step(1);
        chk("to_fault", fetch_fault, 1);
        chk("to_halted", halted, 1);
        chk("to_pc", pc_count, 8'h00);
        chk("to_no_inc", inc_total - inc_base, 0);
        step(5);
        chk("to_fault_sticky", fetch_fault, 1);
        chk("to_no_rd", mem_rd, 0);
`else
        step(40);
        chk("nto_fault", fetch_fault, 0);
        chk("nto_halted", halted, 0);
        chk("nto_rd", mem_rd, 1);
        chk("nto_pc", pc_count, 8'h00);
        chk("nto_no_inc", inc_total - inc_base, 0);
`endif
        mem_ready = 1'b1;

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
